// File: rtl/fft16_stage_ctrl.sv
// Stage sequencer for a 16-point radix-2 DIT FFT: issues butterfly pairs and
// twiddle indices stage by stage, then replays them as write-back strobes.
module fft16_stage_ctrl #(
  parameter int BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [1:0] stage,
  output logic       bfly_valid,
  output logic [3:0] idx0,
  output logic [3:0] idx1,
  output logic [2:0] tw_idx,
  output logic       wr_en,
  output logic [3:0] wr_idx0,
  output logic [3:0] wr_idx1
);

  if (BF_LAT < 1 || BF_LAT > 4) begin : g_bad_lat
    $error("fft16_stage_ctrl: BF_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(BF_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] bfly, bfly_nxt;
  logic [1:0] dcnt, dcnt_nxt;
  logic [1:0] stage_nxt;
  logic       issue;
  logic [3:0] pair0_nxt, pair1_nxt;
  logic [2:0] tw_nxt;

  // {upper index, lower index, twiddle} for butterfly b of stage s.
  function automatic logic [10:0] bfly_index(input logic [1:0] s, input logic [2:0] b);
    logic [3:0] half, pos, grp, lo;
    logic [2:0] tw;
    half = 4'd1 << s;
    pos  = {1'b0, b} & (half - 4'd1);
    grp  = {1'b0, b} >> s;
    lo   = ((grp << s) << 1) + pos;
    tw   = 3'(pos << (2'd3 - s));
    return {lo, lo + half, tw};
  endfunction

  always_comb begin
    state_nxt = state;
    bfly_nxt  = bfly;
    dcnt_nxt  = dcnt;
    stage_nxt = stage;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          bfly_nxt  = 3'd0;
          stage_nxt = 2'd0;
          issue     = 1'b1;
        end
      end
      RUN: begin
        if (bfly == 3'd7) begin
          state_nxt = DRAIN;
          dcnt_nxt  = 2'd0;
        end else begin
          bfly_nxt = bfly + 3'd1;
          issue    = 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == DRAIN_LAST) begin
          if (stage == 2'd3) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage + 2'd1;
            bfly_nxt  = 3'd0;
            issue     = 1'b1;
          end
        end else begin
          dcnt_nxt = dcnt + 2'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort outranks everything, including a start in the same cycle
    if (abort) begin
      state_nxt = IDLE;
      bfly_nxt  = 3'd0;
      dcnt_nxt  = 2'd0;
      stage_nxt = 2'd0;
      issue     = 1'b0;
    end
    {pair0_nxt, pair1_nxt, tw_nxt} = bfly_index(stage_nxt, bfly_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bfly  <= 3'd0;
      dcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      bfly  <= bfly_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // issue stage: registered outputs, index fields hold while not issuing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      stage      <= 2'd0;
      bfly_valid <= 1'b0;
      idx0       <= 4'd0;
      idx1       <= 4'd0;
      tw_idx     <= 3'd0;
    end else begin
      busy       <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done       <= (state_nxt == DONE);
      stage      <= stage_nxt;
      bfly_valid <= issue;
      if (issue) begin
        idx0   <= pair0_nxt;
        idx1   <= pair1_nxt;
        tw_idx <= tw_nxt;
      end
    end
  end

  // write-back stage: BF_LAT-deep delay of {valid, idx0, idx1}
  logic [8:0] wb_pipe [BF_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < BF_LAT; j++) wb_pipe[j] <= 9'd0;
    end else if (abort) begin
      for (int j = 0; j < BF_LAT; j++) wb_pipe[j] <= 9'd0;
    end else begin
      wb_pipe[0] <= {bfly_valid, idx0, idx1};
      for (int j = 1; j < BF_LAT; j++) wb_pipe[j] <= wb_pipe[j-1];
    end
  end

  assign {wr_en, wr_idx0, wr_idx1} = wb_pipe[BF_LAT-1];

endmodule

// File: tb/tb_fft16_stage_ctrl.sv
// Scoreboard bench: three sequencers (BF_LAT = 1, 2, 4) share stimulus and are
// checked against a transform-level model of the issue/write/done streams.
module tb_fft16_stage_ctrl;

  typedef struct packed {
    int         cyc;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic [1:0] st;
    logic [2:0] n;
  } rec_t;

  function automatic int lat_of(int l);
    return (l == 0) ? 1 : (l == 1) ? 2 : 4;
  endfunction

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  int   ecnt = 0;
  int   nchk = 0, nfail = 0;

  logic       busy [3], done [3], bv [3], wr [3];
  logic [1:0] stg [3];
  logic [3:0] i0 [3], i1 [3], wi0 [3], wi1 [3];
  logic [2:0] tw [3];

  for (genvar g = 0; g < 3; g++) begin : lane
    fft16_stage_ctrl #(.BF_LAT(lat_of(g))) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .busy       (busy[g]),
      .done       (done[g]),
      .stage      (stg[g]),
      .bfly_valid (bv[g]),
      .idx0       (i0[g]),
      .idx1       (i1[g]),
      .tw_idx     (tw[g]),
      .wr_en      (wr[g]),
      .wr_idx0    (wi0[g]),
      .wr_idx1    (wi1[g])
    );
  end

  // ecnt is the number of the rising edge just taken; the interval after it is cycle ecnt+1
  initial begin
    forever begin
      #5;
      ecnt++;
      clk = 1'b1;
      #5;
      clk = 1'b0;
    end
  end

  function automatic void chk(string name, int l, longint act, longint exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s lane_lat%0d cycle %0d: got 0x%0h, expected 0x%0h",
               name, lat_of(l), ecnt + 1, act, exp);
    end
  endfunction

  rec_t       iss_q [3][$];
  rec_t       wr_q  [3][$];
  int         done_q[3][$];
  int         free_at [3] = '{0, 0, 0};
  int         act_beg [3] = '{1, 1, 1};
  int         act_end [3] = '{0, 0, 0};
  logic [15:0] mask [3];

  // Reference model: a transform accepted at edge e issues stage s pair n on
  // cycle e+1+s*P+n, writes it back L cycles later and pulses done at e+4P+1.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int l = 0; l < 3; l++) begin
        int L, P;
        L = lat_of(l);
        P = 8 + L;
        if (!rst_n || abort) begin
          while (iss_q[l].size() > 0 && iss_q[l][$].cyc > ecnt) void'(iss_q[l].pop_back());
          while (wr_q[l].size() > 0 && wr_q[l][$].cyc > ecnt) void'(wr_q[l].pop_back());
          while (done_q[l].size() > 0 && done_q[l][$] > ecnt) void'(done_q[l].pop_back());
          if (act_end[l] > ecnt) act_end[l] = ecnt;
          free_at[l] = ecnt + 1;
        end else if (start && ecnt >= free_at[l]) begin
          for (int s = 0; s < 4; s++) begin
            int n;
            n = 0;
            for (int k = 0; k < 16; k++) begin
              if (((k >> s) & 1) == 0) begin
                rec_t r;
                r.cyc = ecnt + 1 + s * P + n;
                r.a   = 4'(k);
                r.b   = 4'(k + (1 << s));
                r.tw  = 3'((k % (1 << s)) * (8 >> s));
                r.st  = 2'(s);
                r.n   = 3'(n);
                iss_q[l].push_back(r);
                r.cyc = r.cyc + L;
                wr_q[l].push_back(r);
                n++;
              end
            end
          end
          done_q[l].push_back(ecnt + 4 * P + 1);
          act_beg[l] = ecnt + 1;
          act_end[l] = ecnt + 4 * P;
          free_at[l] = ecnt + 4 * P + 2;
        end
      end
    end
  end

  // Monitor: compares every cycle's strobes and payloads with the queue heads
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int l = 0; l < 3; l++) begin
          int   cur;
          logic ev, ew, ed;
          rec_t r;
          cur = ecnt + 1;
          ev = (iss_q[l].size() > 0) && (iss_q[l][0].cyc == cur);
          chk("bfly_valid", l, longint'(bv[l]), longint'(ev));
          if (ev) begin
            r = iss_q[l].pop_front();
            if (bv[l]) begin
              chk("issue", l, longint'({i0[l], i1[l], tw[l], stg[l]}), longint'({r.a, r.b, r.tw, r.st}));
              if (r.n == 3'd0) mask[l] = 16'd0;
              mask[l] = mask[l] | (16'd1 << i0[l]) | (16'd1 << i1[l]);
              if (r.n == 3'd7) chk("stage_cover", l, longint'(mask[l]), 64'hffff);
            end
          end
          ew = (wr_q[l].size() > 0) && (wr_q[l][0].cyc == cur);
          chk("wr_en", l, longint'(wr[l]), longint'(ew));
          if (ew) begin
            r = wr_q[l].pop_front();
            if (wr[l]) chk("wr_idx", l, longint'({wi0[l], wi1[l]}), longint'({r.a, r.b}));
          end
          ed = (done_q[l].size() > 0) && (done_q[l][0] == cur);
          chk("done", l, longint'(done[l]), longint'(ed));
          if (ed) void'(done_q[l].pop_front());
          chk("busy", l, longint'(busy[l]), longint'(cur >= act_beg[l] && cur <= act_end[l]));
        end
      end
    end
  end

  task automatic to_cycle(int c);
    while (ecnt + 1 < c) @(negedge clk);
  endtask

  task automatic pulse_start(int e);
    to_cycle(e);
    start = 1'b1;
    to_cycle(e + 1);
    start = 1'b0;
  endtask

  task automatic chk_zero(string name);
    for (int l = 0; l < 3; l++)
      chk(name, l, longint'({busy[l], done[l], stg[l], bv[l], i0[l], i1[l], tw[l], wr[l], wi0[l], wi1[l]}), 0);
  endtask

  initial begin
    int e0, e1, e2, e3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_zero("idle_outputs");

    // Reference run, stray starts at +5, +20 and the done cycle
    e0 = ecnt + 3;
    pulse_start(e0);
    chk("c1_issue", 1, longint'({bv[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 4'd0, 4'd1, 3'd0}));
    pulse_start(e0 + 5);
    to_cycle(e0 + 8);
    chk("c8_issue", 1, longint'({bv[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 4'd14, 4'd15, 3'd0}));
    to_cycle(e0 + 10);
    chk("c10_drain_hold", 1, longint'({bv[1], stg[1], i0[1], i1[1], tw[1]}), longint'({1'b0, 2'd0, 4'd14, 4'd15, 3'd0}));
    to_cycle(e0 + 11);
    chk("c11_issue", 1, longint'({bv[1], stg[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 2'd1, 4'd0, 4'd2, 3'd0}));
    to_cycle(e0 + 12);
    chk("c12_issue", 1, longint'({bv[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 4'd1, 4'd3, 3'd4}));
    pulse_start(e0 + 20);
    to_cycle(e0 + 31);
    chk("c31_issue", 1, longint'({bv[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 4'd0, 4'd8, 3'd0}));
    to_cycle(e0 + 38);
    chk("c38_issue", 1, longint'({bv[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 4'd7, 4'd15, 3'd7}));
    to_cycle(e0 + 40);
    chk("c40_write", 1, longint'({wr[1], wi0[1], wi1[1]}), longint'({1'b1, 4'd7, 4'd15}));
    to_cycle(e0 + 41);
    chk("c41_done", 1, longint'({done[1], busy[1]}), longint'({1'b1, 1'b0}));
    start = 1'b1;
    to_cycle(e0 + 42);
    start = 1'b0;
    chk("c42_idle", 1, longint'({done[1], busy[1]}), 0);
    to_cycle(e0 + 43);
    chk("c43_no_restart", 1, longint'(bv[1]), 0);
    to_cycle(e0 + 100);

    // Abort with stage-1 writes in flight, then a clean restart
    e1 = ecnt + 3;
    pulse_start(e1);
    to_cycle(e1 + 15);
    abort = 1'b1;
    to_cycle(e1 + 16);
    abort = 1'b0;
    chk("abort_quiet", 1, longint'({busy[1], wr[1], done[1]}), 0);
    pulse_start(e1 + 17);
    chk("restart_issue", 1, longint'({bv[1], i0[1], i1[1], tw[1]}), longint'({1'b1, 4'd0, 4'd1, 3'd0}));
    to_cycle(e1 + 80);

    // Randomized start/abort traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (80) @(negedge clk);

    // Asynchronous reset in the middle of the first drain
    e2 = ecnt + 3;
    pulse_start(e2);
    to_cycle(e2 + 9);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    to_cycle(e2 + 12);
    rst_n = 1'b1;
    e3 = ecnt + 3;
    pulse_start(e3);
    to_cycle(e3 + 41);
    chk("post_reset_done", 1, longint'({done[1], busy[1]}), longint'({1'b1, 1'b0}));
    to_cycle(e3 + 80);

    for (int l = 0; l < 3; l++) begin
      chk("issue_left", l, longint'(iss_q[l].size()), 0);
      chk("write_left", l, longint'(wr_q[l].size()), 0);
      chk("done_left", l, longint'(done_q[l].size()), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
